// File: rtl/stack_pkg.sv
// Shared stack constants, push-source encodings and the stack FSM state type.
package stack_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 16;

    localparam logic SRC_EXT = 1'b0;
    localparam logic SRC_ULA = 1'b1;

    typedef enum logic [0:0] {
        S_OK  = 1'b0,
        S_ERR = 1'b1
    } stack_state_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: synchronous write, two combinational read ports (top and next-to-top).
module stack_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/stack_unit.sv
// Operand stack driven by edge-detected control-unit strobes; errors freeze the stack until reset.
module stack_unit
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clock_pilha,
    input  logic              pilha_wren,
    input  logic              controle_pilha,
    input  logic [DATA_W-1:0] data_pilha,
    input  logic [DATA_W-1:0] ula_result,
    output logic [DATA_W-1:0] dado_pop,
    output logic              pop_valid,
    output logic [DATA_W-1:0] topo,
    output logic [ADDR_W:0]   sp,
    output logic              vazia,
    output logic              cheia,
    output logic              erro_overflow,
    output logic              erro_underflow
);

    localparam int unsigned SP_W = ADDR_W + 1;

    stack_state_e      state_q, state_d;
    logic              strobe_q, strobe_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0] topo_q, topo_d;
    logic [DATA_W-1:0] dado_pop_q, dado_pop_d;
    logic              pop_valid_q, pop_valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              accept_c, full_c, empty_c, we_c;
    logic [DATA_W-1:0] src_c, rd_top_c, rd_next_c;

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock  (clock),
        .we     (we_c & ~reset),
        .waddr  (ADDR_W'(sp_q)),
        .wdata  (src_c),
        .raddr0 (ADDR_W'(sp_q - SP_W'(1))),
        .raddr1 (ADDR_W'(sp_q - SP_W'(2))),
        .rdata0 (rd_top_c),
        .rdata1 (rd_next_c)
    );

    assign accept_c = clock_pilha & ~strobe_q;
    assign full_c   = (sp_q == SP_W'(DEPTH));
    assign empty_c  = (sp_q == '0);
    assign src_c    = (controle_pilha == SRC_ULA) ? ula_result : data_pilha;

    // Command decode: one command per rising strobe, ignored once an error has latched.
    always_comb begin
        state_d     = state_q;
        strobe_d    = clock_pilha;
        sp_d        = sp_q;
        topo_d      = topo_q;
        dado_pop_d  = dado_pop_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        we_c        = 1'b0;
        if (accept_c && state_q == S_OK) begin
            if (pilha_wren) begin
                if (full_c) begin
                    ovf_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    we_c   = 1'b1;
                    sp_d   = sp_q + SP_W'(1);
                    topo_d = src_c;
                end
            end else begin
                if (empty_c) begin
                    udf_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    dado_pop_d  = rd_top_c;
                    pop_valid_d = 1'b1;
                    sp_d        = sp_q - SP_W'(1);
                    topo_d      = (sp_q == SP_W'(1)) ? '0 : rd_next_c;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_OK;
            strobe_q    <= 1'b0;
            sp_q        <= '0;
            topo_q      <= '0;
            dado_pop_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            strobe_q    <= strobe_d;
            sp_q        <= sp_d;
            topo_q      <= topo_d;
            dado_pop_q  <= dado_pop_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign dado_pop       = dado_pop_q;
    assign pop_valid      = pop_valid_q;
    assign topo           = topo_q;
    assign sp             = sp_q;
    assign vazia          = empty_c;
    assign cheia          = full_c;
    assign erro_overflow  = ovf_q;
    assign erro_underflow = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: queue-based reference model checked every cycle, plus directed literal checks.
module tb_stack_unit;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              clock_pilha = 1'b0;
    logic              pilha_wren = 1'b0;
    logic              controle_pilha = 1'b0;
    logic [DATA_W-1:0] data_pilha = '0;
    logic [DATA_W-1:0] ula_result = '0;
    logic [DATA_W-1:0] dado_pop;
    logic              pop_valid;
    logic [DATA_W-1:0] topo;
    logic [ADDR_W:0]   sp;
    logic              vazia, cheia, erro_overflow, erro_underflow;

    stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .clock_pilha    (clock_pilha),
        .pilha_wren     (pilha_wren),
        .controle_pilha (controle_pilha),
        .data_pilha     (data_pilha),
        .ula_result     (ula_result),
        .dado_pop       (dado_pop),
        .pop_valid      (pop_valid),
        .topo           (topo),
        .sp             (sp),
        .vazia          (vazia),
        .cheia          (cheia),
        .erro_overflow  (erro_overflow),
        .erro_underflow (erro_underflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stack is a queue; an error simply freezes everything.
    logic [DATA_W-1:0] mq[$];
    bit                m_prev = 1'b0;
    bit                m_err = 1'b0;
    bit                m_pv = 1'b0;
    bit                m_ovf = 1'b0;
    bit                m_udf = 1'b0;
    logic [DATA_W-1:0] m_dado = '0;
    bit                started = 1'b0;

    always @(posedge clock) begin
        bit acc;
        started = 1'b1;
        if (reset) begin
            mq.delete();
            m_prev = 1'b0; m_err = 1'b0; m_pv = 1'b0;
            m_ovf = 1'b0;  m_udf = 1'b0; m_dado = '0;
        end else begin
            m_pv   = 1'b0;
            acc    = clock_pilha && !m_prev;
            m_prev = clock_pilha;
            if (acc && !m_err) begin
                if (pilha_wren) begin
                    if (mq.size() == DEPTH) begin
                        m_ovf = 1'b1; m_err = 1'b1;
                    end else begin
                        mq.push_back(controle_pilha ? ula_result : data_pilha);
                    end
                end else begin
                    if (mq.size() == 0) begin
                        m_udf = 1'b1; m_err = 1'b1;
                    end else begin
                        m_dado = mq.pop_back();
                        m_pv   = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("sp",        32'(sp),             32'(mq.size()));
            chk("topo",      32'(topo),           (mq.size() > 0) ? 32'(mq[mq.size()-1]) : 32'd0);
            chk("dado_pop",  32'(dado_pop),       32'(m_dado));
            chk("pop_valid", 32'(pop_valid),      32'(m_pv));
            chk("vazia",     32'(vazia),          32'(mq.size() == 0));
            chk("cheia",     32'(cheia),          32'(mq.size() == DEPTH));
            chk("overflow",  32'(erro_overflow),  32'(m_ovf));
            chk("underflow", 32'(erro_underflow), 32'(m_udf));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clock_pilha = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // One strobe pulse; pv/dp are the outputs right after the accepting edge.
    task automatic cmd(input bit push, input bit sel, input logic [7:0] d, input logic [7:0] u,
                       output bit pv, output logic [7:0] dp);
        clock_pilha = 1'b1; pilha_wren = push; controle_pilha = sel;
        data_pilha = d; ula_result = u;
        tick();
        pv = pop_valid; dp = dado_pop;
        clock_pilha = 1'b0;
        data_pilha = $urandom; ula_result = $urandom;
        tick();
    endtask

    bit         pv;
    logic [7:0] dp;
    int         push_pct;

    initial begin
        tick();
        reset = 1'b0;
        chk("rst_sp", 32'(sp), 32'd0);
        chk("rst_vazia", 32'(vazia), 32'd1);

        // LIFO order with external source
        cmd(1, 0, 8'h11, 8'hEE, pv, dp);
        cmd(1, 0, 8'h22, 8'hEE, pv, dp);
        cmd(1, 0, 8'h33, 8'hEE, pv, dp);
        chk("t1_sp3", 32'(sp), 32'd3);
        chk("t1_topo", 32'(topo), 32'h33);
        cmd(0, 0, 8'h00, 8'h00, pv, dp);
        chk("t1_pop1", {24'd0, dp}, 32'h33); chk("t1_pv1", 32'(pv), 32'd1);
        cmd(0, 0, 8'h00, 8'h00, pv, dp);
        chk("t1_pop2", {24'd0, dp}, 32'h22); chk("t1_pv2", 32'(pv), 32'd1);
        cmd(0, 0, 8'h00, 8'h00, pv, dp);
        chk("t1_pop3", {24'd0, dp}, 32'h11); chk("t1_pv3", 32'(pv), 32'd1);
        chk("t1_sp0", 32'(sp), 32'd0);
        chk("t1_vazia", 32'(vazia), 32'd1);
        chk("t1_topo0", 32'(topo), 32'd0);

        // ALU source select
        cmd(1, 1, 8'h5A, 8'hA5, pv, dp);
        chk("t2_topo", 32'(topo), 32'hA5);
        chk("t2_sp", 32'(sp), 32'd1);

        // Overflow freezes the stack
        do_reset();
        for (int i = 0; i < DEPTH; i++) cmd(1, 0, 8'(i + 1), 8'h00, pv, dp);
        chk("t3_cheia", 32'(cheia), 32'd1);
        cmd(1, 0, 8'hEE, 8'h00, pv, dp);
        chk("t3_ovf", 32'(erro_overflow), 32'd1);
        chk("t3_sp", 32'(sp), 32'd16);
        chk("t3_topo", 32'(topo), 32'h10);
        cmd(0, 0, 8'h00, 8'h00, pv, dp);
        chk("t3_pop_pv", 32'(pv), 32'd0);
        chk("t3_pop_sp", 32'(sp), 32'd16);

        // Underflow freezes the stack
        do_reset();
        cmd(0, 0, 8'h00, 8'h00, pv, dp);
        chk("t4_udf", 32'(erro_underflow), 32'd1);
        chk("t4_pv", 32'(pv), 32'd0);
        chk("t4_dado", 32'(dado_pop), 32'd0);
        cmd(1, 0, 8'h44, 8'h00, pv, dp);
        chk("t4_sp", 32'(sp), 32'd0);

        // A held strobe gives exactly one command
        do_reset();
        clock_pilha = 1'b1; pilha_wren = 1'b1; controle_pilha = 1'b0; data_pilha = 8'h77;
        tick(); tick(); tick();
        chk("t5_sp1", 32'(sp), 32'd1);
        clock_pilha = 1'b0;
        tick();
        clock_pilha = 1'b1; data_pilha = 8'h78;
        tick();
        clock_pilha = 1'b0;
        chk("t5_sp2", 32'(sp), 32'd2);
        chk("t5_topo", 32'(topo), 32'h78);
        tick();

        // Reset beats a coincident pop strobe
        reset = 1'b1; clock_pilha = 1'b1; pilha_wren = 1'b0;
        tick();
        chk("t6_sp", 32'(sp), 32'd0);
        chk("t6_pv", 32'(pop_valid), 32'd0);
        chk("t6_vazia", 32'(vazia), 32'd1);
        chk("t6_err", {30'd0, erro_overflow, erro_underflow}, 32'd0);
        reset = 1'b0; clock_pilha = 1'b0;
        tick();

        // Random traffic with occasional resets; bias toward pushes varies per reset epoch
        push_pct = 75;
        for (int c = 0; c < 4000; c++) begin
            reset          = ($urandom_range(0, 249) == 0);
            if (reset) push_pct = ($urandom_range(0, 2) == 0) ? 55 : (($urandom_range(0, 1) == 0) ? 75 : 92);
            clock_pilha    = $urandom_range(0, 1);
            pilha_wren     = ($urandom_range(0, 99) < push_pct);
            controle_pilha = $urandom_range(0, 1);
            data_pilha     = $urandom;
            ula_result     = $urandom;
            tick();
        end
        reset = 1'b0; clock_pilha = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
